result_drain: RTL and testbench
===============================

// Module: result_drain
// PURPOSE
// - Downstream stage of the 2x2 systolic matrix core: captures one finished result set (z11,z12,z21,z22) on a done pulse.
// - Streams the set out as four words over a valid/ready interface, in the order z11, z12, z21, z22.
// - Holds one pending set so the core can start its next product while the current set drains.
// PARAMETERS
// - RES_W  32  width of each result element; must equal 4*matrix_pkg::indata_size
// - IDX_W  2   width of out_idx (element index, fixed 4 elements)
// PORTS
// - clk          in   1      clock
// - reset        in   1      synchronous, active-high reset
// - done_i       in   1      1-cycle pulse: z* inputs hold a complete, valid result set
// - z11_i        in   RES_W  signed result element row1,col1
// - z12_i        in   RES_W  signed result element row1,col2
// - z21_i        in   RES_W  signed result element row2,col1
// - z22_i        in   RES_W  signed result element row2,col2
// - out_ready    in   1      consumer ready
// - clr_overrun  in   1      clears sticky overrun flag
// - out_data     out  RES_W  current element
// - out_valid    out  1      out_data/out_idx/out_last valid
// - out_idx      out  IDX_W  element index 0..3 (0=z11, 1=z12, 2=z21, 3=z22)
// - out_last     out  1      high with idx 3 (last element of the set)
// - busy         out  1      active or pending buffer occupied
// - overrun      out  1      sticky: a result set was dropped
// BEHAVIOUR
// - Reset: out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, overrun=0. Both buffers are marked empty.
// - Reset mid-stream discards the active and pending sets. It takes priority over all other inputs.
// - Storage
//   - active buffer: 4xRES_W, holding the set being streamed
//   - pending buffer: 4xRES_W plus a pend_vld flag
// - FSM IDLE
//   - done_i=1: latch z* into active, idx<=0, go to SEND.
//   - out_valid rises the cycle after done_i (latency 1).
// - FSM SEND
//   - out_valid=1, out_data=active[idx], out_last=(idx==3).
//   - Transfer occurs when out_valid && out_ready. On transfer with idx<3: idx<=idx+1.
//   - No transfer: all outputs hold stable. Valid must not drop and data must not change until accepted.
// - Last transfer (idx==3 && out_ready), resolved in this order:
//   - pend_vld=1: pending->active, idx<=0, stay in SEND. If done_i is also high, z*->pending and pend_vld stays 1.
//   - pend_vld=0 and done_i=1: z*->active directly, idx<=0, stay in SEND. No gap cycle.
//   - otherwise: go to IDLE and out_valid<=0.
// - done_i in SEND, not on the last transfer:
//   - pend_vld=0: z*->pending, pend_vld<=1.
//   - pend_vld=1: the new set is dropped, overrun<=1, and pending is unchanged.
// - overrun clearing
//   - clr_overrun=1 clears overrun next cycle.
//   - A simultaneous new drop wins, so overrun stays 1.
// - busy = (state==SEND) | pend_vld.
// - Arithmetic: data passes through unmodified (except under RESULT_RELU_EN). Values are treated as signed two's complement.
// - Back-to-back sets with out_ready held high give exactly 4 words per set, with no bubbles.
// CONFIGURATION
// - RESULT_RELU_EN defined
//   - Each element is replaced by 0 if negative (MSB=1), otherwise passed unchanged.
//   - Applied when latching into a buffer, so the output stays a direct register read.
// - RESULT_RELU_EN undefined: elements are streamed exactly as captured.
// TESTING
// - Single set: done_i with z=1,-2,3,-4 and out_ready=1 -> cycles N+1..N+4 give data 1,-2,3,-4, idx 0..3, last on 4th; then out_valid=0.
// - Backpressure: out_ready=0 for 3 cycles at idx1 -> data=-2 and idx=1 hold stable; on release, resumes with 3,-4.
// - Double buffer: second done_i (z=5,6,7,8) at idx1 -> after -4 the next word is 5 with no bubble; overrun=0.
// - Overrun: third done_i while pending is full -> overrun=1 and the third set is never output; clr_overrun -> overrun=0.
// - Simultaneous: done_i coincides with the last transfer, pending empty -> next cycle data=new z11, idx=0, out_valid=1.
// - Reset mid-stream at idx2 with pending full -> next cycle out_valid=0, busy=0; nothing more is output.
// - RESULT_RELU_EN: set -7,0,9,-1 -> output 0,0,9,0.

Source files
------------

// File: rtl/result_drain.sv
// Result drain: captures a 2x2 result set on done_i and streams z11,z12,z21,z22 over valid/ready,
// with one pending set of double buffering. Optional `RESULT_RELU_EN clamps negative elements to 0 at capture.
module result_drain #(
  parameter int RES_W = 32,
  parameter int IDX_W = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    done_i,
  input  logic signed [RES_W-1:0] z11_i,
  input  logic signed [RES_W-1:0] z12_i,
  input  logic signed [RES_W-1:0] z21_i,
  input  logic signed [RES_W-1:0] z22_i,
  input  logic                    out_ready,
  input  logic                    clr_overrun,
  output logic signed [RES_W-1:0] out_data,
  output logic                    out_valid,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_last,
  output logic                    busy,
  output logic                    overrun
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state, state_nxt;
  logic [3:0][RES_W-1:0]  act, pend, z_in;
  logic                   pend_vld, pend_vld_nxt;
  logic [IDX_W-1:0]       idx, idx_nxt;
  logic                   ld_act_z, ld_act_pend, ld_pend_z, drop;
  logic                   xfer, last_xfer;

  function automatic logic [RES_W-1:0] relu(input logic [RES_W-1:0] x);
`ifdef RESULT_RELU_EN
    return x[RES_W-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  // Clamp at capture so the output path stays a plain register read.
  assign z_in[0] = relu(z11_i);
  assign z_in[1] = relu(z12_i);
  assign z_in[2] = relu(z21_i);
  assign z_in[3] = relu(z22_i);

  assign xfer      = (state == SEND) && out_ready;
  assign last_xfer = xfer && (idx == IDX_W'(3));

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    pend_vld_nxt = pend_vld;
    ld_act_z     = 1'b0;
    ld_act_pend  = 1'b0;
    ld_pend_z    = 1'b0;
    drop         = 1'b0;
    case (state)
      IDLE: begin
        if (done_i) begin
          ld_act_z  = 1'b1;
          idx_nxt   = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (last_xfer) begin
          idx_nxt = '0;
          if (pend_vld) begin
            ld_act_pend = 1'b1;
            ld_pend_z   = done_i;
            pend_vld_nxt = done_i;
          end else if (done_i) begin
            ld_act_z = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          if (xfer) idx_nxt = idx + IDX_W'(1);
          if (done_i) begin
            if (pend_vld) drop = 1'b1;
            else begin
              ld_pend_z    = 1'b1;
              pend_vld_nxt = 1'b1;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      pend_vld <= 1'b0;
      act      <= '0;
      pend     <= '0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      pend_vld <= pend_vld_nxt;
      if (ld_act_z)         act <= z_in;
      else if (ld_act_pend) act <= pend;
      if (ld_pend_z)        pend <= z_in;
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

  assign out_valid = (state == SEND);
  assign out_data  = act[idx];
  assign out_idx   = idx;
  assign out_last  = (state == SEND) && (idx == IDX_W'(3));
  assign busy      = (state == SEND) || pend_vld;

endmodule

// File: tb/tb_result_drain.sv
// Scoreboard bench for result_drain: expected words are queued when a set is driven
// and popped on every out_valid && out_ready handshake.
module tb_result_drain;
  localparam int RES_W = 32;
  localparam int IDX_W = 2;

  logic                    clk = 1'b0;
  logic                    reset, done_i, out_ready, clr_overrun;
  logic signed [RES_W-1:0] z11_i, z12_i, z21_i, z22_i;
  logic signed [RES_W-1:0] out_data;
  logic                    out_valid, out_last, busy, overrun;
  logic [IDX_W-1:0]        out_idx;

  typedef struct {
    logic [RES_W-1:0] d;
    logic [IDX_W-1:0] i;
    logic             l;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  result_drain #(.RES_W(RES_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .done_i(done_i),
    .z11_i(z11_i), .z12_i(z12_i), .z21_i(z21_i), .z22_i(z22_i),
    .out_ready(out_ready), .clr_overrun(clr_overrun),
    .out_data(out_data), .out_valid(out_valid), .out_idx(out_idx),
    .out_last(out_last), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [RES_W-1:0] obs, input logic [RES_W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [RES_W-1:0] model(input int v);
    logic [RES_W-1:0] x;
    x = RES_W'(v);
`ifdef RESULT_RELU_EN
    if (v < 0) x = '0;
`endif
    return x;
  endfunction

  // Drive a done pulse for one cycle; queue its words only if the set should appear.
  task automatic send(input int a, input int b, input int c, input int d, input bit push);
    int v[4];
    v = '{a, b, c, d};
    done_i = 1'b1;
    z11_i = a; z12_i = b; z21_i = c; z22_i = d;
    if (push)
      for (int k = 0; k < 4; k++) q.push_back('{model(v[k]), IDX_W'(k), (k == 3)});
  endtask

  task automatic step();
    @(posedge clk); #1;
    done_i = 1'b0;
    clr_overrun = 1'b0;
  endtask

  task automatic drain_idle(input string tag);
    int n = 0;
    while ((out_valid || q.size() != 0) && n < 50) begin step(); n++; end
    chk({tag, "_idle"}, out_valid, 1'b0);
    chk({tag, "_qempty"}, q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_word", out_data, 'x);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("data", out_data, e.d);
        chk("idx", out_idx, e.i);
        chk("last", out_last, e.l);
      end
    end
  end

  initial begin
    reset = 1'b1; done_i = 0; out_ready = 1; clr_overrun = 0;
    z11_i = 0; z12_i = 0; z21_i = 0; z22_i = 0;
    step(); step();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b0;
    step();

    // Single set, latency 1
    send(1, -2, 3, -4, 1);
    step();
    chk("lat1_valid", out_valid, 1);
    chk("lat1_busy", busy, 1);
    drain_idle("single");
    chk("single_busy", busy, 0);

    // Backpressure at idx1
    send(1, -2, 3, -4, 1);
    step(); step();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, model(-2));
      chk("bp_idx", out_idx, 1);
    end
    out_ready = 1'b1;
    drain_idle("bp");

    // Double buffer: no bubble across the set boundary
    send(1, -2, 3, -4, 1);
    step();
    for (int k = 0; k < 8; k++) begin
      chk("db_nobubble", out_valid, 1);
      if (k == 1) send(5, 6, 7, 8, 1);
      step();
    end
    chk("db_end", out_valid, 0);
    chk("db_overrun", overrun, 0);
    drain_idle("db");

    // Overrun: third set dropped; clear racing a new drop keeps the flag
    send(1, 2, 3, 4, 1);
    step();
    send(11, 12, 13, 14, 1);
    step();
    chk("ov_pre", overrun, 0);
    send(21, 22, 23, 24, 0);
    step();
    chk("ov_set", overrun, 1);
    send(31, 32, 33, 34, 0);
    clr_overrun = 1'b1;
    step();
    chk("ov_race", overrun, 1);
    drain_idle("ov");
    clr_overrun = 1'b1;
    step();
    chk("ov_clr", overrun, 0);

    // done_i coincides with the last transfer, pending empty
    send(1, 2, 3, 4, 1);
    step(); step(); step(); step();
    chk("sim_idx3", out_idx, 3);
    send(-9, 8, -7, 6, 1);
    step();
    chk("sim_valid", out_valid, 1);
    chk("sim_idx", out_idx, 0);
    chk("sim_data", out_data, model(-9));
    drain_idle("sim");

    // Reset mid-stream at idx2 with pending full
    send(1, 2, 3, 4, 1);
    step();
    send(5, 6, 7, 8, 1);
    step();
    step();
    chk("mr_idx2", out_idx, 2);
    reset = 1'b1;
    q.delete();
    step();
    reset = 1'b0;
    chk("mr_valid", out_valid, 0);
    chk("mr_busy", busy, 0);
    for (int k = 0; k < 6; k++) step();
    chk("mr_quiet", out_valid, 0);

    // Sign handling (clamped when RESULT_RELU_EN is defined)
    send(-7, 0, 9, -1, 1);
    step();
    drain_idle("relu");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not end");
    $fatal(1);
  end
endmodule
